// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write bus shared by the loader and its environment.
interface instr_loader_if #(
    parameter int ADDR_W = 7
) ();
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    // The loader consumes the stream and drives the memory bus.
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    // The environment produces the stream and observes the memory bus.
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/instr_loader.sv
// Instruction loader: receives a length-prefixed little-endian byte stream,
// writes 32-bit words into instruction memory and releases the cpu reset
// once the whole image has been written.
module instr_loader #(
    parameter int DEPTH_WORDS = 128,
    parameter int ADDR_W      = 7
) (
    input  logic              clk,
    input  logic              rst,
    instr_loader_if.slave     bus,
    input  logic              reload,
    output logic              cpu_rst,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_LEN0  = 3'd0,
        S_LEN1  = 3'd1,
        S_DATA  = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [1:0]        lane_q, lane_d;
    logic [23:0]       word_q, word_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic              in_ready_c;
    logic              accept;
    logic [15:0]       len_full;
    logic [ADDR_W:0]   words_next;
    logic              last_word;

    assign accept     = bus.in_valid & in_ready_c;
    // Full word count as it stands once the high length byte arrives.
    assign len_full   = {bus.in_data, len_q[7:0]};
    assign words_next = words_q + 1'b1;
    // The word currently being completed is the final one of the image.
    assign last_word  = (16'(words_next) == len_q);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_LEN0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode driven by accepted bytes and reload requests.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LEN0: begin
                if (accept) state_d = S_LEN1;
            end
            S_LEN1: begin
                if (accept) begin
                    if (len_full == 16'd0)
                        state_d = S_DONE;
                    else if ({1'b0, len_full} > DEPTH_L)
                        state_d = S_ERR;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept && lane_q == 2'd3 && last_word) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                state_d = S_DONE;
            end
            S_DONE, S_ERR: begin
                if (reload) state_d = S_LEN0;
            end
            default: begin
                state_d = S_LEN0;
            end
        endcase
    end

    // Control outputs decoded from the current state.
    always_comb begin
        in_ready_c = 1'b0;
        cpu_rst    = 1'b1;
        done       = 1'b0;
        err        = 1'b0;
        case (state_q)
            S_LEN0, S_LEN1, S_DATA: in_ready_c = 1'b1;
            S_DONE: begin
                cpu_rst = 1'b0;
                done    = 1'b1;
            end
            S_ERR:   err = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state: length capture, byte-lane assembly and write issue.
    always_comb begin
        len_d       = len_q;
        lane_d      = lane_q;
        word_d      = word_q;
        words_d     = words_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_LEN0: begin
                if (accept) begin
                    len_d[7:0] = bus.in_data;
                    lane_d     = 2'd0;
                end
            end
            S_LEN1: begin
                if (accept) len_d[15:8] = bus.in_data;
            end
            S_DATA: begin
                if (accept) begin
                    case (lane_q)
                        2'd0: word_d[7:0]   = bus.in_data;
                        2'd1: word_d[15:8]  = bus.in_data;
                        2'd2: word_d[23:16] = bus.in_data;
                        default: begin
                            // Fourth byte completes the word: write it at the running word index.
                            mem_we_d    = 1'b1;
                            mem_addr_d  = words_q[ADDR_W-1:0];
                            mem_wdata_d = {bus.in_data, word_q};
                            words_d     = words_next;
                        end
                    endcase
                    lane_d = lane_q + 2'd1;
                end
            end
            S_DONE, S_ERR: begin
                if (reload) begin
                    len_d   = 16'd0;
                    lane_d  = 2'd0;
                    words_d = '0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset discards any partially assembled word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q       <= 16'd0;
            lane_q      <= 2'd0;
            word_q      <= 24'd0;
            words_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
        end else begin
            len_q       <= len_d;
            lane_q      <= lane_d;
            word_q      <= word_d;
            words_q     <= words_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign words_loaded  = words_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed and random load streams
// compared against a stream-level reference model.
module tb_instr_loader;

    localparam int DEPTH = 128;
    localparam int AW    = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          reload = 1'b0;
    logic          cpu_rst;
    logic          done;
    logic          err;
    logic [AW:0]   words_loaded;

    instr_loader_if #(.ADDR_W(AW)) bus ();

    instr_loader #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .reload       (reload),
        .cpu_rst      (cpu_rst),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed memory writes and the cycle of the latest cpu_rst falling edge.
    logic [AW-1:0] obs_addr[$];
    logic [31:0]   obs_data[$];
    int            fall_cyc = -1;
    logic          prev_cpu = 1'b1;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            obs_addr.push_back(bus.mem_addr);
            obs_data.push_back(bus.mem_wdata);
        end
        if (prev_cpu === 1'b1 && cpu_rst === 1'b0) fall_cyc <= cyc;
        prev_cpu <= cpu_rst;
    end

    int            n_cmp = 0;
    int            n_mis = 0;
    logic [7:0]    stream[$];
    int            obs_base = 0;
    int            last_acc_cyc = 0;
    logic [AW-1:0] hold_addr = '0;
    logic [31:0]   hold_data = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offer the first cnt bytes of stream, optionally with idle gaps and ignored reload pulses.
    task automatic send(input int cnt, input bit gaps, input bit rr);
        bit ok;
        for (int i = 0; i < cnt; i++) begin
            ok = 1'b0;
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk);
                    bus.in_valid = 1'b0;
                    bus.in_data  = 8'($urandom);
                    reload       = rr && ($urandom_range(0, 3) == 0);
                end
            end
            for (int t = 0; t < 50 && !ok; t++) begin
                @(negedge clk);
                bus.in_valid = 1'b1;
                bus.in_data  = stream[i];
                reload       = rr && ($urandom_range(0, 3) == 0);
                if (bus.in_ready === 1'b1) begin
                    last_acc_cyc = cyc;
                    ok = 1'b1;
                end
            end
            if (!ok) check("accept_timeout", 64'(0), 64'(1));
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        reload       = 1'b0;
    endtask

    // Compare the final state and written image with the stream-level model.
    task automatic finish_check(input string nm);
        int          n;
        int          nexp;
        int          nobs;
        bit          exp_err;
        bit          term;
        logic [31:0] w;
        n       = int'(stream[0]) + 256 * int'(stream[1]);
        exp_err = (n > DEPTH);
        nexp    = exp_err ? 0 : n;
        term    = 1'b0;
        for (int t = 0; t < 40 && !term; t++) begin
            @(negedge clk);
            if (done === 1'b1 || err === 1'b1) term = 1'b1;
        end
        check({nm, ".terminated"}, 64'(term), 64'(1));
        @(negedge clk);
        check({nm, ".done"}, 64'(done), 64'(!exp_err));
        check({nm, ".err"}, 64'(err), 64'(exp_err));
        check({nm, ".cpu_rst"}, 64'(cpu_rst), 64'(exp_err));
        check({nm, ".in_ready"}, 64'(bus.in_ready), 64'(0));
        check({nm, ".words_loaded"}, 64'(words_loaded), 64'(nexp));
        nobs = obs_addr.size() - obs_base;
        check({nm, ".write_count"}, 64'(nobs), 64'(nexp));
        for (int k = 0; k < nexp && k < nobs; k++) begin
            w = 32'd0;
            for (int j = 0; j < 4; j++) w = w | (32'(stream[2 + 4 * k + j]) << (8 * j));
            check({nm, ".waddr"}, 64'(obs_addr[obs_base + k]), 64'(k));
            check({nm, ".wdata"}, 64'(obs_data[obs_base + k]), 64'(w));
            hold_addr = AW'(k);
            hold_data = w;
        end
        if (!exp_err) begin
            check({nm, ".cpu_rst_fall"}, 64'(fall_cyc),
                  64'((n == 0) ? last_acc_cyc + 1 : last_acc_cyc + 2));
        end
        check({nm, ".mem_we_idle"}, 64'(bus.mem_we), 64'(0));
        check({nm, ".hold_addr"}, 64'(bus.mem_addr), 64'(hold_addr));
        check({nm, ".hold_data"}, 64'(bus.mem_wdata), 64'(hold_data));
    endtask

    task automatic do_reload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check("reload.cpu_rst", 64'(cpu_rst), 64'(1));
        check("reload.done", 64'(done), 64'(0));
        check("reload.err", 64'(err), 64'(0));
        check("reload.in_ready", 64'(bus.in_ready), 64'(1));
        check("reload.words_loaded", 64'(words_loaded), 64'(0));
        obs_base = obs_addr.size();
    endtask

    task automatic make_random(input int n);
        stream.delete();
        stream.push_back(8'(n));
        stream.push_back(8'(n >> 8));
        for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom));
    endtask

    task automatic check_reset_values(input string nm);
        check({nm, ".cpu_rst"}, 64'(cpu_rst), 64'(1));
        check({nm, ".mem_we"}, 64'(bus.mem_we), 64'(0));
        check({nm, ".mem_addr"}, 64'(bus.mem_addr), 64'(0));
        check({nm, ".mem_wdata"}, 64'(bus.mem_wdata), 64'(0));
        check({nm, ".done"}, 64'(done), 64'(0));
        check({nm, ".err"}, 64'(err), 64'(0));
        check({nm, ".words_loaded"}, 64'(words_loaded), 64'(0));
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;

        // Asynchronous reset: outputs forced before any clock edge.
        #2 rst = 1'b1;
        #1 check_reset_values("rst_async");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_release.in_ready", 64'(bus.in_ready), 64'(1));
        obs_base = obs_addr.size();

        // Two-word program, no gaps.
        stream = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h73, 8'h00, 8'h10, 8'h00};
        send(10, 1'b0, 1'b0);
        finish_check("two_words");
        do_reload();

        // Empty image.
        stream = '{8'h00, 8'h00};
        send(2, 1'b0, 1'b0);
        finish_check("empty");
        do_reload();

        // Same two-word program with idle gaps.
        stream = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h73, 8'h00, 8'h10, 8'h00};
        send(10, 1'b1, 1'b0);
        finish_check("two_words_gaps");
        do_reload();

        // Oversize length: error, no further bytes consumed.
        stream = '{8'h81, 8'h00};
        send(2, 1'b0, 1'b0);
        finish_check("oversize");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 8'($urandom);
            check("oversize.blocked", 64'(bus.in_ready), 64'(0));
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("oversize.still_err", 64'(err), 64'(1));
        check("oversize.no_writes", 64'(obs_addr.size() - obs_base), 64'(0));
        do_reload();

        // Random images with gaps and ignored reload pulses during the load.
        for (int r = 0; r < 6; r++) begin
            make_random($urandom_range(1, 6));
            send(stream.size(), 1'b1, 1'b1);
            finish_check("random");
            do_reload();
        end

        // Largest legal image fills the whole memory.
        make_random(DEPTH);
        send(stream.size(), 1'b0, 1'b0);
        finish_check("full_depth");
        do_reload();

        // Reset mid-load, then a one-word image.
        make_random(3);
        send(6, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1 check_reset_values("rst_midload");
        @(negedge clk);
        rst = 1'b0;
        hold_addr = '0;
        hold_data = '0;
        obs_base  = obs_addr.size();
        @(negedge clk);
        check("rst_midload.in_ready", 64'(bus.in_ready), 64'(1));
        stream = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send(6, 1'b0, 1'b0);
        finish_check("after_rst");
        check("after_rst.deadbeef", 64'(bus.mem_wdata), 64'(32'hDEADBEEF));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
